cache_refill_ctrl: RTL

Miss-handling engine between the direct-mapped cache array (512 lines × 128 bits, 19-bit tag, 9-bit index) and the line-granular backing memory. On a miss it writes back the dirty victim line, issues a line read, waits for the memory's CAS-delayed response, then drives a one-cycle fill write into the cache array. It is the memory-side initiator for the 128-bit `rd`/`wren`/`data_out_valid` memory port.

---
 rtl/cache_pkg.sv | 29 ++
 rtl/cache_refill_ctrl_if.sv | 40 ++++
 rtl/cache_refill_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared widths, FSM state type and address helpers for the cache miss/refill engine.
package cache_pkg;

   localparam int unsigned TAG_W   = 19;
   localparam int unsigned IDX_W   = 9;
   localparam int unsigned LINE_W  = 128;
   localparam int unsigned LADDR_W = TAG_W + IDX_W;
   localparam int unsigned MADDR_W = 32;

   typedef enum logic [2:0] {
      StIdle,
      StWb,
      StRdReq,
      StRdWait,
      StFill,
      StDone
   } refill_state_t;

   // Memory is line granular; the low nibble of a byte address is always zero.
   function automatic logic [MADDR_W-1:0] line_to_byte_addr(input logic [LADDR_W-1:0] line);
      return {line, 4'h0};
   endfunction

   function automatic logic [MADDR_W-1:0] victim_byte_addr(input logic [TAG_W-1:0] tag,
                                                          input logic [IDX_W-1:0] idx);
      return {tag, idx, 4'h0};
   endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Miss-request and memory-port signals of the refill engine, bundled as one interface.
interface cache_refill_ctrl_if;
   import cache_pkg::*;

   logic                miss_req;
   logic [LADDR_W-1:0]  miss_addr;
   logic                victim_dirty;
   logic [TAG_W-1:0]    victim_tag;
   logic [LINE_W-1:0]   victim_line;
   logic                busy;
   logic                miss_done;
   logic                miss_err;
   logic                fill_wren;
   logic [LADDR_W-1:0]  fill_addr;
   logic [LINE_W-1:0]   fill_line;
   logic [MADDR_W-1:0]  mem_addr;
   logic [LINE_W-1:0]   mem_wdata;
   logic                mem_wren;
   logic                mem_rd;
   logic                mem_ready;
   logic [LINE_W-1:0]   mem_rdata;
   logic                mem_rdata_valid;

   // The refill controller: target of miss requests, initiator on the memory port.
   modport master (
      input  miss_req, miss_addr, victim_dirty, victim_tag, victim_line,
      input  mem_ready, mem_rdata, mem_rdata_valid,
      output busy, miss_done, miss_err, fill_wren, fill_addr, fill_line,
      output mem_addr, mem_wdata, mem_wren, mem_rd
   );

   // The surrounding cache pipeline and memory model.
   modport slave (
      output miss_req, miss_addr, victim_dirty, victim_tag, victim_line,
      output mem_ready, mem_rdata, mem_rdata_valid,
      input  busy, miss_done, miss_err, fill_wren, fill_addr, fill_line,
      input  mem_addr, mem_wdata, mem_wren, mem_rd
   );

endinterface

// File: rtl/cache_refill_ctrl.sv
// Miss-handling FSM: dirty write-back, line read with bounded wait, one-cycle cache fill.
module cache_refill_ctrl
   import cache_pkg::*;
#(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                reset,
   cache_refill_ctrl_if.master bus
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
   localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

   refill_state_t       state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                err_q, err_d;
   logic [LADDR_W-1:0]  addr_q, addr_d;
   logic [TAG_W-1:0]    vtag_q, vtag_d;
   logic [LINE_W-1:0]   vline_q, vline_d;
   logic [LINE_W-1:0]   fill_line_q, fill_line_d;
   logic [MADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                merr_q, merr_d;
   logic                fill_wren_q, fill_wren_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      addr_d      = addr_q;
      vtag_d      = vtag_q;
      vline_d     = vline_q;
      fill_line_d = fill_line_q;

      unique case (state_q)
         StIdle: begin
            if (bus.miss_req) begin
               addr_d  = bus.miss_addr;
               vtag_d  = bus.victim_tag;
               vline_d = bus.victim_line;
               state_d = bus.victim_dirty ? StWb : StRdReq;
            end
         end
         StWb: begin
            if (bus.mem_ready) begin
               state_d = StRdReq;
            end
         end
         StRdReq: begin
            if (bus.mem_ready) begin
               state_d = StRdWait;
               cnt_d   = '0;
            end
         end
         StRdWait: begin
            if (cnt_q != CntMax) begin
               cnt_d = cnt_q + 1'b1;
            end
            // Returned data beats the timeout when both land in the same cycle.
            if (bus.mem_rdata_valid) begin
               fill_line_d = bus.mem_rdata;
               state_d     = StFill;
            end else if (cnt_q >= CntLast) begin
               err_d   = 1'b1;
               state_d = StDone;
            end
         end
         StFill: begin
            state_d = StDone;
         end
         StDone: begin
            err_d   = 1'b0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Moore outputs are registered from the next state so they align with state_q.
      busy_d      = (state_d != StIdle);
      done_d      = (state_d == StDone);
      merr_d      = (state_d == StDone) && err_d;
      fill_wren_d = (state_d == StFill);
      if (state_d == StWb) begin
         mem_addr_d = victim_byte_addr(vtag_d, addr_d[IDX_W-1:0]);
      end else if (state_d == StRdReq) begin
         mem_addr_d = line_to_byte_addr(addr_d);
      end else begin
         mem_addr_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         addr_q      <= '0;
         vtag_q      <= '0;
         vline_q     <= '0;
         fill_line_q <= '0;
         mem_addr_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         merr_q      <= 1'b0;
         fill_wren_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         addr_q      <= addr_d;
         vtag_q      <= vtag_d;
         vline_q     <= vline_d;
         fill_line_q <= fill_line_d;
         mem_addr_q  <= mem_addr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         merr_q      <= merr_d;
         fill_wren_q <= fill_wren_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.miss_done = done_q;
   assign bus.miss_err  = merr_q;
   assign bus.fill_wren = fill_wren_q;
   assign bus.fill_addr = addr_q;
   assign bus.fill_line = fill_line_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = vline_q;

   // Commands are only issued in a cycle the memory accepts them.
   assign bus.mem_wren = (state_q == StWb) && bus.mem_ready;
   assign bus.mem_rd   = (state_q == StRdReq) && bus.mem_ready;

endmodule
